bf_bus_arbiter: RTL and testbench

Sequences and shares the single multiplexed 8-bit external memory bus (address phase, then data phase on the shared data pins) between two requesters: the Brainfuck core FSM (port 0) and the host program loader/debug port (port 1). It sits between the requesters and the tristate pad group. It drives the write and address strobes, the output data, and the output enable, and it returns the read data. It runs a per-transaction state machine with programmable data-phase wait states.

---
 rtl/bf_bus_pkg.sv | 17 +
 rtl/bf_bus_pick.sv | 28 ++
 rtl/bf_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_bf_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf_bus_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// BF_BUS_ARB_RR_EN selects round-robin arbitration (see bf_bus_pick).
package bf_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StAck
  } bus_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bf_bus_pick.sv
// Combinational winner select between core (port 0) and host (port 1).
// BF_BUS_ARB_RR_EN defined: round-robin on ties; undefined: host always wins.
module bf_bus_pick
  import bf_bus_pkg::*;
(
  input  logic [1:0] req,
`ifdef BF_BUS_ARB_RR_EN
  input  logic       last,
`endif
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
`ifdef BF_BUS_ARB_RR_EN
    // On a tie the port not granted last wins.
    if (req == 2'b11) begin
      idx = ~last;
    end else begin
      idx = req[1] ? PORT_HOST : PORT_CORE;
    end
`else
    idx = req[1] ? PORT_HOST : PORT_CORE;
`endif
  end

endmodule

// File: rtl/bf_bus_arbiter.sv
// Two-port arbiter and sequencer for the multiplexed 8-bit external memory bus.
// BF_BUS_ARB_RR_EN enables round-robin arbitration; otherwise host has fixed priority.
module bf_bus_arbiter
  import bf_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [7:0] bus_out,
  input  logic [7:0] bus_in,
  output logic       bus_oe,
  output logic       addr_stb,
  output logic       wr_stb
);

  localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WAIT_CYCLES);

  bus_state_e       state_q, state_d;
  logic             idx_q, idx_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;

  logic pick_valid;
  logic pick_idx;

`ifdef BF_BUS_ARB_RR_EN
  logic last_q, last_d;
`endif

  bf_bus_pick u_pick (
    .req   (req),
`ifdef BF_BUS_ARB_RR_EN
    .last  (last_q),
`endif
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef BF_BUS_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Requester inputs are only ever sampled here.
        if (ena && pick_valid) begin
          state_d = StAddr;
          idx_d   = pick_idx;
          we_d    = pick_idx ? we[1] : we[0];
          addr_d  = pick_idx ? addr1 : addr0;
          wdata_d = pick_idx ? wdata1 : wdata0;
`ifdef BF_BUS_ARB_RR_EN
          last_d  = pick_idx;
`endif
        end
      end
      StAddr: begin
        cnt_d   = WaitInit;
        state_d = StData;
      end
      StData: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = bus_in;
          end
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= PORT_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef BF_BUS_ARB_RR_EN
      last_q  <= PORT_HOST;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef BF_BUS_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Pad and strobe outputs decode only registered state and latched fields.
  always_comb begin
    ack      = 2'b00;
    bus_out  = 8'h00;
    bus_oe   = 1'b0;
    addr_stb = 1'b0;
    wr_stb   = 1'b0;
    busy     = (state_q != StIdle);
    rdata    = rdata_q;
    unique case (state_q)
      StIdle: begin
      end
      StAddr: begin
        bus_out  = addr_q;
        addr_stb = 1'b1;
        bus_oe   = 1'b1;
      end
      StData: begin
        if (we_q) begin
          bus_out = wdata_q;
          wr_stb  = 1'b1;
          bus_oe  = 1'b1;
        end
      end
      StAck: begin
        ack[idx_q] = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bf_bus_arbiter.sv
// Self-checking bench: two arbiters (WAIT_CYCLES=1 and 0) share stimulus and are
// compared each cycle against a transaction-timeline model; honours BF_BUS_ARB_RR_EN.
module tb_bf_bus_arbiter;

`ifdef BF_BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr0, addr1, wdata0, wdata1, bus_in;

  logic [1:0] ack_w      [2];
  logic [7:0] rdata_w    [2];
  logic       busy_w     [2];
  logic [7:0] bus_out_w  [2];
  logic       bus_oe_w   [2];
  logic       addr_stb_w [2];
  logic       wr_stb_w   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_bus_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_w[0]), .rdata(rdata_w[0]), .busy(busy_w[0]),
    .bus_out(bus_out_w[0]), .bus_in(bus_in), .bus_oe(bus_oe_w[0]),
    .addr_stb(addr_stb_w[0]), .wr_stb(wr_stb_w[0])
  );

  bf_bus_arbiter #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_w[1]), .rdata(rdata_w[1]), .busy(busy_w[1]),
    .bus_out(bus_out_w[1]), .bus_in(bus_in), .bus_oe(bus_oe_w[1]),
    .addr_stb(addr_stb_w[1]), .wr_stb(wr_stb_w[1])
  );

  // Model: m_p counts cycles since grant (0 = idle, 1 = address phase,
  // 2..w+2 = data phase, w+3 = ack cycle).
  int         wv      [2] = '{1, 0};
  int         m_p     [2];
  logic       m_idx   [2];
  logic       m_we    [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];
  logic       m_last  [2];
  logic [1:0] ack_seen [2];
  int         grants  [2][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic winner(input logic [1:0] r, input logic last);
    if (r == 2'b11) return RR ? ~last : 1'b1;
    return r[1];
  endfunction

  task automatic step();
    logic       s_rst, s_ena, w;
    logic [1:0] s_req, s_we;
    logic [7:0] s_a0, s_a1, s_d0, s_d1, s_in;
    logic       e_astb, e_data, e_wr;
    logic [7:0] e_out;
    logic [1:0] e_ack;
    int         p;
    s_rst = rst; s_ena = ena; s_req = req; s_we = we;
    s_a0 = addr0; s_a1 = addr1; s_d0 = wdata0; s_d1 = wdata1; s_in = bus_in;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (s_rst) begin
        m_p[d] = 0; m_rdata[d] = 8'h00; m_last[d] = 1'b1;
      end else if (m_p[d] == 0) begin
        if (s_ena && s_req != 2'b00) begin
          w = winner(s_req, m_last[d]);
          m_idx[d]   = w;
          m_we[d]    = s_we[w];
          m_addr[d]  = w ? s_a1 : s_a0;
          m_wdata[d] = w ? s_d1 : s_d0;
          m_last[d]  = w;
          grants[d][w]++;
          m_p[d] = 1;
        end
      end else begin
        if (m_p[d] == wv[d] + 2 && !m_we[d]) m_rdata[d] = s_in;
        m_p[d] = (m_p[d] == wv[d] + 3) ? 0 : m_p[d] + 1;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      p      = m_p[d];
      e_astb = (p == 1);
      e_data = (p >= 2) && (p <= wv[d] + 2);
      e_wr   = e_data && m_we[d];
      e_out  = e_astb ? m_addr[d] : (e_wr ? m_wdata[d] : 8'h00);
      e_ack  = (p == wv[d] + 3) ? (2'b01 << m_idx[d]) : 2'b00;
      check($sformatf("dut%0d_ack", d), 32'(ack_w[d]), 32'(e_ack));
      check($sformatf("dut%0d_rdata", d), 32'(rdata_w[d]), 32'(m_rdata[d]));
      check($sformatf("dut%0d_busy", d), 32'(busy_w[d]), 32'(p != 0));
      check($sformatf("dut%0d_bus_out", d), 32'(bus_out_w[d]), 32'(e_out));
      check($sformatf("dut%0d_bus_oe", d), 32'(bus_oe_w[d]), 32'(e_astb || e_wr));
      check($sformatf("dut%0d_addr_stb", d), 32'(addr_stb_w[d]), 32'(e_astb));
      check($sformatf("dut%0d_wr_stb", d), 32'(wr_stb_w[d]), 32'(e_wr));
      ack_seen[d] |= ack_w[d];
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int stb_count;
    for (int d = 0; d < 2; d++) begin
      m_p[d] = 0; m_idx[d] = 0; m_we[d] = 0; m_addr[d] = 0; m_wdata[d] = 0;
      m_rdata[d] = 0; m_last[d] = 1; ack_seen[d] = 0; grants[d][0] = 0; grants[d][1] = 0;
    end
    rst = 1'b1; ena = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00; bus_in = 8'h00;
    steps(2);
    rst = 1'b0;
    step();
    check("reset_busy", 32'(busy_w[0]), 32'd0);
    check("reset_rdata", 32'(rdata_w[0]), 32'd0);

    // Core read with WAIT_CYCLES=1 (and 0 on the second instance).
    ena = 1'b1; req = 2'b01; we = 2'b00; addr0 = 8'h10; bus_in = 8'hA5;
    step();
    req = 2'b00;
    check("core_rd_addr_stb", 32'(addr_stb_w[0]), 32'd1);
    check("core_rd_addr", 32'(bus_out_w[0]), 32'h10);
    steps(2);
    check("core_rd_oe_low", 32'(bus_oe_w[0]), 32'd0);
    step();
    check("core_rd_ack", 32'(ack_w[0]), 32'b01);
    check("core_rd_rdata", 32'(rdata_w[0]), 32'hA5);
    check("core_rd_w0_rdata", 32'(rdata_w[1]), 32'hA5);
    steps(2);

    // Host write.
    req = 2'b10; we = 2'b10; addr1 = 8'h3F; wdata1 = 8'h7E; bus_in = 8'h00;
    step();
    req = 2'b00;
    check("host_wr_addr", 32'(bus_out_w[0]), 32'h3F);
    step();
    check("host_wr_data", 32'(bus_out_w[0]), 32'h7E);
    check("host_wr_stb", 32'(wr_stb_w[0]), 32'd1);
    steps(2);
    check("host_wr_ack", 32'(ack_w[0]), 32'b10);
    step();

    // Simultaneous requests held continuously.
    for (int d = 0; d < 2; d++) begin grants[d][0] = 0; grants[d][1] = 0; end
    req = 2'b11; we = 2'b01; addr0 = 8'h21; addr1 = 8'h42; wdata0 = 8'h5A; bus_in = 8'hC3;
    steps(30);
    req = 2'b00;
    steps(6);
    if (RR) check("rr_balance", 32'(grants[0][0] - grants[0][1] + 1), 32'd1);
    else    check("fixed_core_starved", 32'(grants[0][0]), 32'd0);

    // Reset during a data phase, then a fresh core request.
    req = 2'b01; we = 2'b00; addr0 = 8'h55; bus_in = 8'h99;
    step();
    req = 2'b00;
    steps(2);
    for (int d = 0; d < 2; d++) ack_seen[d] = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    check("rst_mid_rdata", 32'(rdata_w[0]), 32'd0);
    step();
    check("rst_mid_no_ack", 32'(ack_seen[0]), 32'd0);
    req = 2'b01; addr0 = 8'h66; bus_in = 8'h3C;
    step();
    req = 2'b00;
    steps(5);
    check("post_rst_rdata", 32'(rdata_w[0]), 32'h3C);

    // Grant enable held low, then released and dropped in the address phase.
    ena = 1'b0; req = 2'b01; addr0 = 8'h77;
    stb_count = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (addr_stb_w[0] || addr_stb_w[1]) stb_count++;
    end
    check("ena_low_no_stb", 32'(stb_count), 32'd0);
    ena = 1'b1;
    for (int d = 0; d < 2; d++) ack_seen[d] = 2'b00;
    step();
    check("ena_grant", 32'(addr_stb_w[0]), 32'd1);
    ena = 1'b0; req = 2'b00;
    steps(5);
    check("ena_drop_ack_w1", 32'(ack_seen[0]), 32'b01);
    check("ena_drop_ack_w0", 32'(ack_seen[1]), 32'b01);
    ena = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      ena    = ($urandom_range(0, 7) != 0);
      req    = 2'($urandom);
      we     = 2'($urandom);
      addr0  = 8'($urandom); addr1  = 8'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      bus_in = 8'($urandom);
      step();
    end
    rst = 1'b0; req = 2'b00;
    steps(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
